fix_msg_packer: RTL and testbench
=================================

Name: fix_msg_packer

Overview:
- Ingress stage directly upstream of the dual-port message RAM.
- Accepts the byte stream of framed FIX messages and packs bytes little-endian into 32-bit words.
- Writes words into the RAM through its port 0 as a circular buffer.
- When a message completes, posts a descriptor (start word, length) to the downstream parser, which later returns the freed space as credits.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width; RAM_DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, RAM word width; fixed at 32 (4 bytes/word); any other value is a compile-time error.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_data  in  8  message byte
- in_eom  in  1  qualifies the last byte of a message
- in_err  in  1  abort current message (sampled with an accepted byte)
- ram_addr  out  ADDR_WIDTH  port-0 address
- ram_data  out  32  port-0 write data
- ram_cs  out  1  port-0 chip select
- ram_we  out  1  port-0 write enable
- ram_oe  out  1  port-0 output enable; constant 0
- desc_valid  out  1  descriptor valid
- desc_ready  in  1  descriptor accepted when desc_valid && desc_ready
- desc_start  out  ADDR_WIDTH  first word address of the message
- desc_words  out  ADDR_WIDTH+1  words used, 1..RAM_DEPTH
- desc_bytes  out  ADDR_WIDTH+3  exact byte count
- desc_cksum  out  8  byte checksum (see Optional Feature)
- rel_valid  in  1  credit return strobe
- rel_words  in  ADDR_WIDTH+1  words released by consumer
- ovf_pulse  out  1  one-cycle pulse: message dropped, larger than RAM

Behaviour:

Reset:
- Asynchronous, active-low; all outputs and state go to 0.
- State IDLE, wr_ptr = 0, occ = 0.

States: IDLE, PACK, POST, DROP.
- IDLE: in_ready = (occ < RAM_DEPTH).
  - First accepted byte latches msg_start = wr_ptr, allocates a word (occ += 1, msg_words = 1) -> PACK.
  - If that byte carries in_eom it is a one-byte message -> POST (via final write below).
- PACK:
  - Byte lanes fill 0..3, byte k at bits [8k+7:8k].
  - in_ready = (byte_idx != 0) || (occ < RAM_DEPTH).
  - A new word needed while msg_words == RAM_DEPTH: the byte is consumed, ovf_pulse fires, the message is rolled back, and the state goes to DROP.
- Word write:
  - Issued when the 4th byte, or an in_eom byte, is accepted.
  - In the following cycle: ram_cs = ram_we = 1 for exactly one cycle, ram_addr = word address, ram_data = packed word.
  - Unfilled lanes of a final partial word are zero.
  - Byte acceptance continues in the same cycle as the write (no bubble).
  - wr_ptr increments modulo RAM_DEPTH, wrapping from RAM_DEPTH-1 to 0.
- POST:
  - Entered after the final write strobe; desc_valid rises the cycle after that strobe, so RAM contents are stable first.
  - in_ready = 0.
  - Descriptor fields are held stable until desc_ready; on handshake go to IDLE.
- in_err on an accepted byte:
  - Rollback: wr_ptr = msg_start, occ -= msg_words; no descriptor is posted.
  - If that byte has in_eom, go to IDLE; otherwise go to DROP.
  - A pending partial word is not written.
- DROP: in_ready = 1, bytes discarded; the byte with in_eom returns to IDLE.

Credits:
- occ += allocations and -= rel_words (rel_valid) in the same cycle; both apply.
- A release larger than occ saturates occ at 0.

Other rules:
- ram_data/ram_addr hold their last value while ram_cs = 0.
- An asynchronous reset mid-message discards the message and zeroes all state.

Optional Feature:
FIX_CKSUM_EN
- Defined: an 8-bit running sum mod 256 of every accepted byte of the message, including the eom byte, is cleared at message start and presented on desc_cksum with the descriptor.
- Undefined: no adder; desc_cksum is constant 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then the 8 bytes 0x38..0x3F with eom on the last -> two writes: addr 0 data 0x3B3A3938, addr 1 data 0x3F3E3D3C; desc start=0, words=2, bytes=8, cksum 0xDC with FIX_CKSUM_EN, else 0.
- 5-byte message 0x01..0x05 -> second word 0x00000005; desc words=2, bytes=5; desc_valid held 10 cycles with desc_ready=0, then a handshake returns to IDLE.
- ADDR_WIDTH=3, wr_ptr=6, 4-word message -> writes at 6,7,0,1; desc_start=6; wr_ptr=2 after.
- ADDR_WIDTH=3, occ=8 with no release -> in_ready stays 0; rel_valid with rel_words=2 -> in_ready=1 next cycle and bytes flow.
- in_err on byte 6 of a message starting at word 3 -> no descriptor, occ and wr_ptr restored to their pre-message values, and the next message starts at word 3.
- ADDR_WIDTH=3, 33-byte message on an empty buffer -> ovf_pulse on byte 33, DROP until eom, occ=0, no descriptor.

Source files
------------

// File: rtl/fix_msg_packer.sv
// fix_msg_packer: packs framed FIX message bytes little-endian into 32-bit
// words, writes them to a circular RAM (port 0) and posts a descriptor per
// message. Freed space comes back from the parser as word credits.
// Ports: in_* byte stream (valid/ready, eom, err); ram_* port-0 write strobe;
// desc_* descriptor (valid/ready); rel_* credit return; ovf_pulse on drop.
// Build option: define FIX_CKSUM_EN for an 8-bit byte checksum on desc_cksum.
module fix_msg_packer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_eom,
  input  logic                  in_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [ADDR_WIDTH-1:0] desc_start,
  output logic [ADDR_WIDTH:0]   desc_words,
  output logic [ADDR_WIDTH+2:0] desc_bytes,
  output logic [7:0]            desc_cksum,
  input  logic                  rel_valid,
  input  logic [ADDR_WIDTH:0]   rel_words,
  output logic                  ovf_pulse
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("fix_msg_packer: DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {IDLE, PACK, POST, DROP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [AW-1:0]   start_q, start_d;
  logic [AW:0]     words_q, words_d;
  logic [AW+2:0]   bytes_q, bytes_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic            cs_q, cs_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            dv_q, dv_d;
  logic            ovf_q, ovf_d;

  logic            take;
  logic            ovf_hit;
  logic            alloc;
  logic            rollback;
  logic [31:0]     packed_w;
  logic [AW+1:0]   sum;
  logic [AW+1:0]   sub;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    start_d  = start_q;
    words_d  = words_q;
    bytes_d  = bytes_q;
    idx_d    = idx_q;
    word_d   = word_q;
    cs_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    dv_d     = dv_q;
    ovf_d    = 1'b0;
    alloc    = 1'b0;
    rollback = 1'b0;
    in_ready = 1'b0;
    // A new word is needed but the message already spans the whole RAM.
    ovf_hit  = (idx_q == 2'd0) && (words_q == FULL);
    // Lane 0 starts a fresh word so unfilled lanes of a tail word are zero.
    packed_w = (idx_q == 2'd0) ? '0 : word_q;
    packed_w[{idx_q, 3'b000} +: 8] = in_data;

    unique case (state_q)
      IDLE:    in_ready = occ_q < FULL;
      PACK:    in_ready = (idx_q != 2'd0) || (occ_q < FULL) || ovf_hit;
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    take = in_valid && in_ready;

    unique case (state_q)
      IDLE, PACK: begin
        if (take) begin
          if (in_err || (state_q == PACK && ovf_hit)) begin
            ovf_d    = !in_err;
            rollback = state_q == PACK;
            if (state_q == PACK) wr_ptr_d = start_q;
            idx_d    = 2'd0;
            state_d  = in_eom ? IDLE : DROP;
          end else begin
            word_d = packed_w;
            if (state_q == IDLE) begin
              start_d = wr_ptr_q;
              words_d = (AW+1)'(1);
              bytes_d = (AW+3)'(1);
              alloc   = 1'b1;
            end else begin
              bytes_d = bytes_q + 1'b1;
              if (idx_q == 2'd0) begin
                alloc   = 1'b1;
                words_d = words_q + 1'b1;
              end
            end
            if (idx_q == 2'd3 || in_eom) begin
              cs_d     = 1'b1;
              addr_d   = wr_ptr_q;
              data_d   = packed_w;
              wr_ptr_d = wr_ptr_q + 1'b1;
              idx_d    = 2'd0;
              state_d  = in_eom ? POST : PACK;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = PACK;
            end
          end
        end
      end
      POST: begin
        // Entered with the final write strobe in flight; valid follows it.
        dv_d = 1'b1;
        if (dv_q && desc_ready) begin
          dv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (take && in_eom) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sum   = {1'b0, occ_q} + {{(AW+1){1'b0}}, alloc};
    sub   = (rollback  ? {1'b0, words_q}   : '0)
          + (rel_valid ? {1'b0, rel_words} : '0);
    occ_d = (sub > sum) ? '0 : (AW+1)'(sum - sub);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      start_q  <= '0;
      words_q  <= '0;
      bytes_q  <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      cs_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      start_q  <= start_d;
      words_q  <= words_d;
      bytes_q  <= bytes_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef FIX_CKSUM_EN
  logic [7:0] cksum_q;
  logic       store;

  assign store = take && !in_err
              && (state_q == IDLE || (state_q == PACK && !ovf_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= '0;
    end else if (store) begin
      cksum_q <= (state_q == IDLE) ? in_data : cksum_q + in_data;
    end
  end

  assign desc_cksum = cksum_q;
`else
  assign desc_cksum = '0;
`endif

  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign ram_cs     = cs_q;
  assign ram_we     = cs_q;
  assign ram_oe     = 1'b0;
  assign desc_valid = dv_q;
  assign desc_start = start_q;
  assign desc_words = words_q;
  assign desc_bytes = bytes_q;
  assign ovf_pulse  = ovf_q;
endmodule

// File: tb/tb_fix_msg_packer.sv
// tb_fix_msg_packer: directed bench for fix_msg_packer on an 8-word RAM.
// Checks writes, descriptors, wrap, credit stall, abort and overflow drop.
module tb_fix_msg_packer;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = '0;
  logic          in_eom = 1'b0;
  logic          in_err = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic          desc_valid;
  logic          desc_ready = 1'b0;
  logic [AW-1:0] desc_start;
  logic [AW:0]   desc_words;
  logic [AW+2:0] desc_bytes;
  logic [7:0]    desc_cksum;
  logic          rel_valid = 1'b0;
  logic [AW:0]   rel_words = '0;
  logic          ovf_pulse;

  fix_msg_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_eom(in_eom), .in_err(in_err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_oe(ram_oe),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_start(desc_start), .desc_words(desc_words),
    .desc_bytes(desc_bytes), .desc_cksum(desc_cksum),
    .rel_valid(rel_valid), .rel_words(rel_words),
    .ovf_pulse(ovf_pulse)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int ovf_cnt = 0;
  int desc_seen = 0;
  int cyc = 0;
  int last_cs_cyc = 0;
  int dv_rise_cyc = 0;
  int we_bad = 0;
  logic dv_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ram_cs) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_data);
      last_cs_cyc = cyc;
    end
    if (ram_we !== ram_cs) we_bad++;
    if (ovf_pulse) ovf_cnt++;
    if (desc_valid && !dv_prev) begin
      desc_seen++;
      dv_rise_cyc = cyc;
    end
    dv_prev = desc_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ck(input logic [7:0] v);
`ifdef FIX_CKSUM_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic send(input logic [7:0] first, input int n,
                      input int err_at);
    for (int i = 1; i <= n; i++) begin
      int w;
      in_valid = 1'b1;
      in_data  = first + 8'(i - 1);
      in_eom   = (i == n);
      in_err   = (i == err_at);
      w = 0;
      while (!in_ready && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) begin
        check("in_ready_timeout", {63'd0, in_ready}, 1);
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_eom   = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic expect_desc(input string tag, input logic [AW-1:0] s,
                             input int w, input int b,
                             input logic [7:0] c);
    int n;
    n = 0;
    while (!desc_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, desc_valid, 1);
    check({tag, "_start"}, desc_start, s);
    check({tag, "_words"}, desc_words, 64'(w));
    check({tag, "_bytes"}, desc_bytes, 64'(b));
    check({tag, "_cksum"}, desc_cksum, ck(c));
  endtask

  task automatic take_desc(input string tag);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check({tag, "_released"}, desc_valid, 0);
  endtask

  task automatic rel(input int n);
    rel_valid = 1'b1;
    rel_words = (AW+1)'(n);
    tick();
    rel_valid = 1'b0;
    rel_words = '0;
  endtask

  task automatic chk_wr(input string tag, input logic [AW-1:0] a,
                        input logic [31:0] d);
    check({tag, "_present"}, 64'(wa_q.size() != 0), 1);
    if (wa_q.size() != 0) begin
      check({tag, "_addr"}, wa_q.pop_front(), a);
      check({tag, "_data"}, wd_q.pop_front(), d);
    end
  endtask

  initial begin
    int seen0;
    int ovf0;
    tick();
    tick();
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_oe", ram_oe, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_desc_valid", desc_valid, 0);
    check("rst_desc_words", desc_words, 0);
    check("rst_ovf", ovf_pulse, 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", in_ready, 1);

    send(8'h38, 8, 0);
    expect_desc("t1", 0, 2, 8, 8'hDC);
    check("t1_dv_latency", 64'(dv_rise_cyc - last_cs_cyc), 1);
    chk_wr("t1_w0", 0, 32'h3B3A3938);
    chk_wr("t1_w1", 1, 32'h3F3E3D3C);
    check("t1_wr_count", 64'(wa_q.size()), 0);
    check("t1_post_ready", in_ready, 0);
    take_desc("t1");
    rel(2);

    send(8'h01, 5, 0);
    expect_desc("t2", 2, 2, 5, 8'h0F);
    chk_wr("t2_w0", 2, 32'h04030201);
    chk_wr("t2_w1", 3, 32'h00000005);
    repeat (10) tick();
    check("t2_hold_valid", desc_valid, 1);
    check("t2_hold_bytes", desc_bytes, 5);
    check("t2_hold_start", desc_start, 2);
    take_desc("t2");
    rel(2);
    check("t2_idle_ready", in_ready, 1);

    send(8'h10, 8, 0);
    expect_desc("fill", 4, 2, 8, 8'h9C);
    chk_wr("fill_w0", 4, 32'h13121110);
    chk_wr("fill_w1", 5, 32'h17161514);
    take_desc("fill");
    rel(2);

    send(8'h40, 16, 0);
    expect_desc("t3", 6, 4, 16, 8'h78);
    chk_wr("t3_w0", 6, 32'h43424140);
    chk_wr("t3_w1", 7, 32'h47464544);
    chk_wr("t3_w2", 0, 32'h4B4A4948);
    chk_wr("t3_w3", 1, 32'h4F4E4D4C);
    take_desc("t3");
    rel(4);

    send(8'h50, 16, 0);
    expect_desc("t4a", 2, 4, 16, 8'h78);
    take_desc("t4a");
    send(8'h60, 16, 0);
    expect_desc("t4b", 6, 4, 16, 8'h78);
    take_desc("t4b");
    wa_q.delete();
    wd_q.delete();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_eom   = 1'b1;
    repeat (3) tick();
    check("t4_full_ready", in_ready, 0);
    check("t4_full_no_write", 64'(wa_q.size()), 0);
    rel(2);
    check("t4_ready_after_rel", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_eom   = 1'b0;
    expect_desc("t4c", 2, 1, 1, 8'hAA);
    chk_wr("t4c_w0", 2, 32'h000000AA);
    take_desc("t4c");
    rel(7);

    seen0 = desc_seen;
    send(8'h01, 7, 6);
    repeat (3) tick();
    check("t5_no_desc", 64'(desc_seen - seen0), 0);
    check("t5_desc_valid", desc_valid, 0);
    chk_wr("t5_partial", 3, 32'h04030201);
    check("t5_wr_count", 64'(wa_q.size()), 0);
    send(8'h80, 32, 0);
    expect_desc("t5b", 3, 8, 32, 8'hF0);
    check("t5b_wr_count", 64'(wa_q.size()), 8);
    chk_wr("t5b_first", 3, 32'h83828180);
    repeat (6) begin
      void'(wa_q.pop_front());
      void'(wd_q.pop_front());
    end
    chk_wr("t5b_last", 2, 32'h9F9E9D9C);
    take_desc("t5b");
    rel(8);

    seen0 = desc_seen;
    ovf0  = ovf_cnt;
    send(8'hC0, 33, 0);
    repeat (2) tick();
    check("t6_ovf_pulses", 64'(ovf_cnt - ovf0), 1);
    check("t6_no_desc", 64'(desc_seen - seen0), 0);
    check("t6_desc_valid", desc_valid, 0);
    check("t6_wr_count", 64'(wa_q.size()), 8);
    check("t6_ready", in_ready, 1);
    wa_q.delete();
    wd_q.delete();
    send(8'hE0, 32, 0);
    expect_desc("t6b", 3, 8, 32, 8'hF0);
    chk_wr("t6b_first", 3, 32'hE3E2E1E0);
    take_desc("t6b");
    rel(8);

    check("we_tracks_cs", 64'(we_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
